// File: rtl/dmem_pkg.sv
// Shared encodings and byte-lane helpers for the sized MEM-stage data memory.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        INIT,
        READY
    } state_t;

    // Byte enables for an access whose offset has already been resolved.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: lane_mask = 4'b0001 << off;
            SZ_HALF: lane_mask = off[1] ? 4'b1100 : 4'b0011;
            default: lane_mask = 4'b1111;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: is_misaligned = 1'b0;
            SZ_HALF: is_misaligned = off[0];
            default: is_misaligned = (off != 2'b00);
        endcase
    endfunction

    function automatic logic [1:0] align_off(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: align_off = off;
            SZ_HALF: align_off = {off[1], 1'b0};
            default: align_off = 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/dmem_sized_if.sv
// MEM-stage data memory bus: load/store request, extended read data, status and debug taps.
interface dmem_sized_if #(
    parameter int ADDR_W   = 7,
    parameter int NUM_TAPS = 2
);
    logic                     mem_read;
    logic                     mem_write;
    logic [ADDR_W-1:0]        addr;
    logic [1:0]               size;
    logic                     load_unsigned;
    logic [31:0]              w_data;
    logic [31:0]              r_data;
    logic                     busy;
    logic                     misalign;
    logic [32*NUM_TAPS-1:0]   tap_data;

    modport master (
        output mem_read, mem_write, addr, size, load_unsigned, w_data,
        input  r_data, busy, misalign, tap_data
    );

    modport slave (
        input  mem_read, mem_write, addr, size, load_unsigned, w_data,
        output r_data, busy, misalign, tap_data
    );
endinterface

// File: rtl/dmem_load_ext.sv
// Load path: picks the addressed byte/half out of a word and sign- or zero-extends it.
module dmem_load_ext
    import dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    input  logic        load_unsigned,
    output logic [31:0] result
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[8*off +: 8];
        half_sel = off[1] ? word[31:16] : word[15:0];
        result   = word;
        case (size)
            SZ_BYTE: result = {{24{~load_unsigned & byte_sel[7]}}, byte_sel};
            SZ_HALF: result = {{16{~load_unsigned & half_sel[15]}}, half_sel};
            default: result = word;
        endcase
    end
endmodule

// File: rtl/dmem_sized.sv
// Sized data memory with post-reset clearing sequencer and debug tap window.
// Build option DMEM_MISALIGN_TRAP_EN: flag and suppress misaligned accesses instead of aligning them.
module dmem_sized
    import dmem_pkg::*;
#(
    parameter int ADDR_W   = 7,
    parameter int NUM_TAPS = 2,
    parameter int TAP_BASE = 1
) (
    input logic         clk,
    input logic         rst,
    dmem_sized_if.slave bus
);
    localparam int WIDX_W = ADDR_W - 2;
    localparam int DEPTH  = 2 ** WIDX_W;

    logic [31:0]       mem [DEPTH];
    state_t            state, state_nxt;
    logic [WIDX_W-1:0] clr_cnt, clr_cnt_nxt;
    logic              busy_c;

    logic [WIDX_W-1:0] widx;
    logic [1:0]        off;
    logic              mis_block;
    logic [3:0]        be;
    logic [31:0]       st_data;
    logic              wr_en;
    logic [31:0]       ld_ext;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= INIT;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        busy_c      = 1'b0;
        case (state)
            INIT: begin
                busy_c      = 1'b1;
                clr_cnt_nxt = clr_cnt + WIDX_W'(1);
                if (clr_cnt == '1) state_nxt = READY;
            end
            READY: ;
            default: state_nxt = INIT;
        endcase
    end

    assign widx = bus.addr[ADDR_W-1:2];

`ifdef DMEM_MISALIGN_TRAP_EN
    assign off          = bus.addr[1:0];
    assign mis_block    = is_misaligned(bus.size, bus.addr[1:0]);
    assign bus.misalign = (bus.mem_read | bus.mem_write) & mis_block & ~busy_c;
`else
    assign off          = align_off(bus.size, bus.addr[1:0]);
    assign mis_block    = 1'b0;
    assign bus.misalign = 1'b0;
`endif

    assign be    = lane_mask(bus.size, off);
    assign wr_en = bus.mem_write & ~busy_c & ~mis_block;

    // Replicating the right-justified store data onto every lane lets the byte enables alone pick the target.
    always_comb begin
        case (bus.size)
            SZ_BYTE: st_data = {4{bus.w_data[7:0]}};
            SZ_HALF: st_data = {2{bus.w_data[15:0]}};
            default: st_data = bus.w_data;
        endcase
    end

    always_ff @(posedge clk) begin
        if (state == INIT) begin
            mem[clr_cnt] <= '0;
        end else if (wr_en) begin
            for (int unsigned k = 0; k < 4; k++) begin
                if (be[k]) mem[widx][8*k +: 8] <= st_data[8*k +: 8];
            end
        end
    end

    dmem_load_ext u_load_ext (
        .word          (mem[widx]),
        .size          (bus.size),
        .off           (off),
        .load_unsigned (bus.load_unsigned),
        .result        (ld_ext)
    );

    assign bus.r_data = (bus.mem_read & ~busy_c & ~mis_block) ? ld_ext : '0;
    assign bus.busy   = busy_c;

    for (genvar i = 0; i < NUM_TAPS; i++) begin : g_tap
        localparam logic [WIDX_W-1:0] TIDX = WIDX_W'(TAP_BASE + i);
        assign bus.tap_data[32*i +: 32] = mem[TIDX];
    end
endmodule

// File: tb/tb_dmem_sized.sv
// Self-checking bench for dmem_sized against a byte-array reference model.
module tb_dmem_sized;
    localparam int ADDR_W   = 7;
    localparam int NUM_TAPS = 2;
    localparam int TAP_BASE = 1;
    localparam int DEPTH    = 32;
    localparam int NBYTES   = 128;
`ifdef DMEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmem_sized_if #(.ADDR_W(ADDR_W), .NUM_TAPS(NUM_TAPS)) bus ();

    dmem_sized #(.ADDR_W(ADDR_W), .NUM_TAPS(NUM_TAPS), .TAP_BASE(TAP_BASE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  mb [NBYTES];
    logic [31:0] obs_r;
    logic        obs_m;
    logic [63:0] obs_tap;

    function automatic int unsigned nbytes(input logic [1:0] sz);
        case (sz)
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit mis_of(input logic [1:0] sz, input int unsigned a);
        return (a % nbytes(sz)) != 0;
    endfunction

    function automatic logic [31:0] model_load(input bit rd, input int unsigned a,
                                              input logic [1:0] sz, input bit uns);
        int unsigned n, ea, v;
        if (!rd) return 32'h0;
        if (TRAP && mis_of(sz, a)) return 32'h0;
        n  = nbytes(sz);
        ea = a - (a % n);
        v  = 0;
        for (int i = 0; i < n; i++) v = v + int'(mb[ea + i]) * (32'd1 << (8 * i));
        if (!uns && n < 4 && v >= (32'd1 << (8 * n - 1))) v = v - (32'd1 << (8 * n));
        return v;
    endfunction

    task automatic model_store(input int unsigned a, input logic [1:0] sz, input logic [31:0] d);
        int unsigned n, ea;
        if (TRAP && mis_of(sz, a)) return;
        n  = nbytes(sz);
        ea = a - (a % n);
        for (int i = 0; i < n; i++) mb[ea + i] = 8'((d >> (8 * i)) & 32'hFF);
    endtask

    function automatic logic [31:0] model_word(input int unsigned w);
        return {mb[4*w+3], mb[4*w+2], mb[4*w+1], mb[4*w]};
    endfunction

    function automatic logic [63:0] model_taps();
        return {model_word(TAP_BASE + 1), model_word(TAP_BASE)};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NBYTES; i++) mb[i] = 8'h00;
    endtask

    task automatic drive(input bit rd, input bit wr, input int unsigned a,
                         input logic [1:0] sz, input bit uns, input logic [31:0] d);
        bus.mem_read      = rd;
        bus.mem_write     = wr;
        bus.addr          = 7'(a);
        bus.size          = sz;
        bus.load_unsigned = uns;
        bus.w_data        = d;
    endtask

    // Drives one access for a full cycle; captures outputs before the committing edge.
    task automatic do_cycle(input bit rd, input bit wr, input int unsigned a,
                            input logic [1:0] sz, input bit uns, input logic [31:0] d);
        drive(rd, wr, a, sz, uns, d);
        @(negedge clk);
        obs_r   = bus.r_data;
        obs_m   = bus.misalign;
        obs_tap = bus.tap_data;
        @(posedge clk);
        #1;
        drive(0, 0, 0, 2'b00, 0, 32'h0);
    endtask

    task automatic test_reset();
        int n;
        int bad;
        drive(0, 0, 0, 2'b00, 0, 32'h0);
        @(posedge clk);
        #1;
        n_tests++;
        if (bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_busy: got %b want 1", bus.busy);
        end
        rst = 1'b0;
        n = 0;
        bad = 0;
        while (n < 200) begin
            drive(1, 0, $urandom_range(0, NBYTES - 1), 2'($urandom_range(0, 3)), 1'($urandom), 32'h0);
            @(negedge clk);
            if (bus.r_data !== 32'h0) bad++;
            @(posedge clk);
            #1;
            n++;
            if (bus.busy !== 1'b1) break;
        end
        drive(0, 0, 0, 2'b00, 0, 32'h0);
        model_clear();
        n_tests++;
        if (n != DEPTH) begin
            n_fail++;
            $display("FAIL reset_busy_cycles: got %0d want %0d", n, DEPTH);
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL reset_busy_rdata: %0d nonzero reads, want 0", bad);
        end
        n_tests++;
        if (bus.tap_data !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_tap: got %h want 0", bus.tap_data);
        end
        for (int i = 0; i < 6; i++) begin
            int unsigned a;
            a = 4 * $urandom_range(0, DEPTH - 1);
            do_cycle(1, 0, a, 2'b10, 0, 32'h0);
            n_tests++;
            if (obs_r !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_read_zero: addr %h got %h want 0", a, obs_r);
            end
        end
    endtask

    task automatic test_store_load();
        logic [31:0] exp_v [5];
        int unsigned a_v [5];
        logic [1:0]  sz_v [5];
        bit          u_v [5];
        do_cycle(0, 1, 8'h08, 2'b10, 0, 32'h11223344); model_store(8'h08, 2'b10, 32'h11223344);
        do_cycle(0, 1, 8'h09, 2'b00, 0, 32'h000000AA); model_store(8'h09, 2'b00, 32'h000000AA);
        do_cycle(0, 1, 8'h0A, 2'b01, 0, 32'h0000BEEF); model_store(8'h0A, 2'b01, 32'h0000BEEF);
        exp_v = '{32'hBEEFAA44, 32'hFFFFFFAA, 32'h000000AA, 32'hFFFFBEEF, 32'h0000BEEF};
        a_v   = '{8, 9, 9, 10, 10};
        sz_v  = '{2'b10, 2'b00, 2'b00, 2'b01, 2'b01};
        u_v   = '{0, 0, 1, 0, 1};
        for (int i = 0; i < 5; i++) begin
            do_cycle(1, 0, a_v[i], sz_v[i], u_v[i], 32'h0);
            n_tests++;
            if (obs_r !== exp_v[i]) begin
                n_fail++;
                $display("FAIL store_load[%0d]: addr %h size %0d uns %0d got %h want %h",
                         i, a_v[i], sz_v[i], u_v[i], obs_r, exp_v[i]);
            end
        end
    endtask

    task automatic test_same_cycle();
        do_cycle(0, 1, 4, 2'b10, 0, 32'hA5A50F0F);
        model_store(4, 2'b10, 32'hA5A50F0F);
        do_cycle(1, 1, 4, 2'b10, 0, 32'h12345678);
        n_tests++;
        if (obs_r !== 32'hA5A50F0F) begin
            n_fail++;
            $display("FAIL same_cycle_old: got %h want %h", obs_r, 32'hA5A50F0F);
        end
        model_store(4, 2'b10, 32'h12345678);
        do_cycle(1, 0, 4, 2'b10, 0, 32'h0);
        n_tests++;
        if (obs_r !== 32'h12345678) begin
            n_fail++;
            $display("FAIL same_cycle_new: got %h want %h", obs_r, 32'h12345678);
        end
        n_tests++;
        if (obs_tap[31:0] !== 32'h12345678) begin
            n_fail++;
            $display("FAIL same_cycle_tap: got %h want %h", obs_tap[31:0], 32'h12345678);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            bit          rd, wr, uns;
            int unsigned a;
            logic [1:0]  sz;
            logic [31:0] d, exp_r;
            logic [63:0] exp_t;
            bit          exp_m;
            rd    = 1'($urandom);
            wr    = 1'($urandom);
            uns   = 1'($urandom);
            a     = $urandom_range(0, NBYTES - 1);
            sz    = 2'($urandom_range(0, 3));
            d     = $urandom;
            exp_r = model_load(rd, a, sz, uns);
            exp_m = TRAP && (rd || wr) && mis_of(sz, a);
            exp_t = model_taps();
            do_cycle(rd, wr, a, sz, uns, d);
            n_tests++;
            if (obs_r !== exp_r) begin
                n_fail++;
                $display("FAIL rand_rdata[%0d]: rd %0d addr %h size %0d uns %0d got %h want %h",
                         i, rd, a, sz, uns, obs_r, exp_r);
            end
            n_tests++;
            if (obs_m !== exp_m) begin
                n_fail++;
                $display("FAIL rand_misalign[%0d]: got %b want %b", i, obs_m, exp_m);
            end
            n_tests++;
            if (obs_tap !== exp_t) begin
                n_fail++;
                $display("FAIL rand_tap[%0d]: got %h want %h", i, obs_tap, exp_t);
            end
            if (wr) model_store(a, sz, d);
        end
    endtask

    task automatic test_misalign();
        do_cycle(0, 1, 8'h0C, 2'b10, 0, 32'h01020304);
        model_store(8'h0C, 2'b10, 32'h01020304);
        do_cycle(0, 1, 8'h0E, 2'b10, 0, 32'hCAFEF00D);
        model_store(8'h0E, 2'b10, 32'hCAFEF00D);
`ifdef DMEM_MISALIGN_TRAP_EN
        n_tests++;
        if (obs_m !== 1'b1) begin
            n_fail++;
            $display("FAIL misalign_store_flag: got %b want 1", obs_m);
        end
        do_cycle(1, 0, 8'h0C, 2'b10, 0, 32'h0);
        n_tests++;
        if (obs_r !== 32'h01020304) begin
            n_fail++;
            $display("FAIL misalign_store_suppressed: got %h want %h", obs_r, 32'h01020304);
        end
        do_cycle(1, 0, 8'h03, 2'b01, 0, 32'h0);
        n_tests++;
        if (obs_m !== 1'b1) begin
            n_fail++;
            $display("FAIL misalign_load_flag: got %b want 1", obs_m);
        end
        n_tests++;
        if (obs_r !== 32'h0) begin
            n_fail++;
            $display("FAIL misalign_load_rdata: got %h want 0", obs_r);
        end
`else
        n_tests++;
        if (obs_m !== 1'b0) begin
            n_fail++;
            $display("FAIL misalign_flag: got %b want 0", obs_m);
        end
        do_cycle(1, 0, 8'h0C, 2'b10, 0, 32'h0);
        n_tests++;
        if (obs_r !== 32'hCAFEF00D) begin
            n_fail++;
            $display("FAIL misalign_aligned_store: got %h want %h", obs_r, 32'hCAFEF00D);
        end
`endif
    endtask

    task automatic test_reset_mid();
        int n;
        do_cycle(0, 1, 8'h0C, 2'b10, 0, 32'hDEADBEEF);
        model_store(8'h0C, 2'b10, 32'hDEADBEEF);
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_tests++;
        if (bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset_busy: got %b want 1", bus.busy);
        end
        @(negedge clk);
        rst = 1'b0;
        drive(1, 0, 8'h0C, 2'b10, 0, 32'h0);
        #1;
        n_tests++;
        if (bus.r_data !== 32'h0) begin
            n_fail++;
            $display("FAIL mid_reset_read_gated: got %h want 0", bus.r_data);
        end
        n = 0;
        while (n < 200) begin
            if (n == 20) drive(0, 1, 4, 2'b10, 0, 32'h55AA55AA);
            else         drive(0, 0, 0, 2'b00, 0, 32'h0);
            @(posedge clk);
            #1;
            n++;
            if (n == 21) begin
                n_tests++;
                if (bus.tap_data[31:0] !== 32'h0) begin
                    n_fail++;
                    $display("FAIL mid_reset_store_ignored: got %h want 0", bus.tap_data[31:0]);
                end
            end
            if (bus.busy !== 1'b1) break;
        end
        drive(0, 0, 0, 2'b00, 0, 32'h0);
        model_clear();
        n_tests++;
        if (n != DEPTH) begin
            n_fail++;
            $display("FAIL mid_reset_busy_cycles: got %0d want %0d", n, DEPTH);
        end
        do_cycle(1, 0, 8'h0C, 2'b10, 0, 32'h0);
        n_tests++;
        if (obs_r !== model_load(1, 8'h0C, 2'b10, 0)) begin
            n_fail++;
            $display("FAIL mid_reset_word3: got %h want 0", obs_r);
        end
        do_cycle(1, 0, 4, 2'b10, 0, 32'h0);
        n_tests++;
        if (obs_r !== 32'h0) begin
            n_fail++;
            $display("FAIL mid_reset_word1: got %h want 0", obs_r);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(0, 0, 0, 2'b00, 0, 32'h0);
        model_clear();
        test_reset();
        test_store_load();
        test_same_cycle();
        test_random();
        test_misalign();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/dmem_sized.md
Name: dmem_sized

Overview:
- Parametrised data memory for the MEM stage of the 5-stage MIPS pipeline.
- Successor to the fixed 32-word, word-only data memory. Adds:
  - clocked byte/half/word stores;
  - sign/zero-extended loads;
  - a post-reset clearing sequencer with a busy flag;
  - a parametrised debug tap window.
- Sits between the EX/MEM and MEM/WB registers. Read is combinational; write commits on the clock edge.

Parameters:
- ADDR_W, 7, byte-address width; depth = 2**(ADDR_W-2) words.
- NUM_TAPS, 2, number of consecutive words exported on tap_data.
- TAP_BASE, 1, word index of the first tapped word; TAP_BASE+NUM_TAPS <= depth.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_read  in  1  load request.
- mem_write  in  1  store request.
- addr  in  ADDR_W  byte address for both load and store.
- size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word).
- load_unsigned  in  1  1 = zero-extend, 0 = sign-extend byte/half loads.
- w_data  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
- r_data  out  32  extended load data.
- busy  out  1  clearing sequence in progress.
- misalign  out  1  misaligned access flag (see Optional Feature).
- tap_data  out  32*NUM_TAPS  word TAP_BASE+i on bits [32i+31:32i], raw contents.

Behaviour:
- Memory layout:
  - depth words of 32 bits, little-endian byte lanes.
  - Byte k of a word occupies bits [8k+7:8k], selected by addr[1:0].
  - Word index is addr[ADDR_W-1:2]; the full range is in bounds, no wrap logic.
- FSM states: INIT, READY.
- Reset behaviour:
  - rst=1 asynchronously forces state=INIT, clear counter=0, busy=1.
  - Array contents are not reset directly.
- INIT:
  - Each cycle writes 0 to word[counter], then counter+1.
  - After the word depth-1 write, next state is READY and busy=0.
  - INIT therefore lasts exactly depth cycles after rst deasserts (32 cycles at default).
  - During INIT, mem_write is ignored and r_data=0.
- Reset mid-INIT restarts from counter 0. Reset in READY re-enters INIT.
- Store (READY, mem_write=1, access permitted):
  - Only the addressed lanes update on the rising edge; other lanes are unchanged.
  - byte: lane addr[1:0] <= w_data[7:0].
  - half: lanes {addr[1],0} and {addr[1],1} <= w_data[15:0], low byte in the lower lane.
  - word: all lanes <= w_data.
- Load:
  - r_data is combinational from addr/size/load_unsigned and current array contents.
  - r_data=0 when mem_read=0 or busy=1.
  - byte/half are extended per load_unsigned.
  - A read of the word being written in the same cycle returns the old contents; new data is visible the next cycle.
- Simultaneous mem_read and mem_write are legal; the read sees pre-write data.
- tap_data always reflects current array contents, including during INIT.

Optional Feature:
- Macro: DMEM_MISALIGN_TRAP_EN.
- Misaligned access means:
  - half with addr[0]=1;
  - word (or size 11) with addr[1:0]!=0.
- Defined:
  - misalign = (mem_read|mem_write) & misaligned & ~busy, combinational.
  - A misaligned store is suppressed (no lane changes).
  - A misaligned load returns r_data=0.
- Undefined:
  - misalign tied 0.
  - Misaligned half/word forcibly aligned by clearing addr[0] (half) or addr[1:0] (word), then executed normally.

Decomposition:
- Package dmem_pkg holds:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10;
  - FSM state encoding;
  - a lane-mask function (size, addr[1:0]) -> 4-bit byte enable.
- One sub-module is natural: dmem_load_ext (combinational lane select + sign/zero extension, 32-bit word in, 32-bit result out).

Test Plan:
- Reset, count cycles: assert rst, release, hold inputs idle -> busy=1 for exactly 32 cycles then 0; tap_data=0; reading any address returns 0.
- Byte/half store, signed and unsigned load: word store 0x11223344 at addr 0x08; byte store 0xAA at addr 0x09; half store 0xBEEF at addr 0x0A.
  - Word load at 0x08 returns 0xBEEFAA44.
  - Signed byte load at 0x09 returns 0xFFFFFFAA; unsigned returns 0x000000AA.
  - Signed half load at 0x0A returns 0xFFFFBEEF.
- Same-cycle read/write: word store 0x12345678 at 0x04 with mem_read on 0x04 in the same cycle -> r_data = old value that cycle, 0x12345678 the next cycle; tap_data[31:0] becomes 0x12345678.
- Reset mid-operation: fill word 3 with 0xDEADBEEF, then pulse rst for 1 cycle mid-clock and release -> busy restarts for 32 cycles; afterwards word 3 reads 0; a store issued during busy is ignored.
- Misaligned store without macro: word store 0xCAFEF00D at 0x0E -> lands at word 3 (0x0C); misalign=0.
- Misaligned store with DMEM_MISALIGN_TRAP_EN: same store -> misalign=1, word 3 unchanged; half load at 0x03 -> misalign=1, r_data=0.
